// File: rtl/vending_pkg.sv
// vending_pkg: shared types and constants for the keypad emulator.
package vending_pkg;

    typedef enum logic [1:0] {IDLE, PRESS_BOUNCE, HOLD, RELEASE_BOUNCE} emu_state_t;

    localparam int KEY_ROWS = 4;
    localparam int KEY_COLS = 4;

    // Fibonacci taps 16,14,13,11 mapped onto bits 15,13,12,10
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/bounce_lfsr.sv
// bounce_lfsr: free-running seedable 16-bit LFSR whose bit 0 drives contact bounce.
module bounce_lfsr
    import vending_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic clk_i,
    input  logic reset_i,
    output logic bit_o
);

    logic [15:0] lfsr_q;

    always_ff @(posedge clk_i) begin
        lfsr_q <= reset_i ? SEED : lfsr_next(lfsr_q);
    end

    assign bit_o = lfsr_q[0];

endmodule

// File: rtl/keypad_matrix_emulator.sv
// keypad_matrix_emulator: 4x4 membrane keypad model with press/release bounce
// and a commanded hold time, answering a scanner on the row/col wires.
module keypad_matrix_emulator
    import vending_pkg::*;
#(
    parameter int          BOUNCE_CYCLES = 64,
    parameter int          BOUNCE_PERIOD = 4,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1,
    parameter bit          ROW_REG       = 1'b0
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                key_valid_i,
    input  logic [3:0]          key_code_i,
    input  logic [15:0]         hold_cycles_i,
    output logic                key_ready_o,
    input  logic [KEY_COLS-1:0] col_i,
    output logic [KEY_ROWS-1:0] row_o,
    output logic                contact_o,
    output logic                busy_o,
    output logic                done_o
);

    localparam logic [15:0] BC = 16'(BOUNCE_CYCLES);
    localparam logic [15:0] BP = 16'(BOUNCE_PERIOD);

    emu_state_t          state_q, state_d;
    logic [15:0]         cnt_q, cnt_d, hold_q, hold_d, ph_q, ph_d;
    logic [3:0]          key_q, key_d;
    logic                contact_q, contact_d, done_q, done_d;
    logic                lfsr_bit;
    logic [KEY_ROWS-1:0] row_fn, row_q;

    bounce_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
        .clk_i  (clk_i),
        .reset_i(reset_i),
        .bit_o  (lfsr_bit)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hold_d    = hold_q;
        key_d     = key_q;
        ph_d      = ph_q;
        contact_d = contact_q;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                contact_d = 1'b0;
                if (key_valid_i) begin
                    key_d     = key_code_i;
                    hold_d    = (hold_cycles_i == '0) ? 16'd1 : hold_cycles_i;
                    cnt_d     = '0;
                    ph_d      = '0;
                    state_d   = (BC == '0) ? HOLD : PRESS_BOUNCE;
                    contact_d = (BC == '0) ? 1'b1 : lfsr_bit;
                end
            end
            PRESS_BOUNCE, RELEASE_BOUNCE: begin
                if (cnt_q == BC - 16'd1) begin
                    cnt_d     = '0;
                    ph_d      = '0;
                    state_d   = (state_q == PRESS_BOUNCE) ? HOLD : IDLE;
                    contact_d = (state_q == PRESS_BOUNCE);
                    done_d    = (state_q == RELEASE_BOUNCE);
                end else begin
                    // contact may only move on period boundaries inside the window
                    cnt_d     = cnt_q + 16'd1;
                    ph_d      = (ph_q == BP - 16'd1) ? '0 : ph_q + 16'd1;
                    contact_d = (ph_q == BP - 16'd1) ? lfsr_bit : contact_q;
                end
            end
            HOLD: begin
                if (cnt_q == hold_q - 16'd1) begin
                    cnt_d     = '0;
                    ph_d      = '0;
                    state_d   = (BC == '0) ? IDLE : RELEASE_BOUNCE;
                    contact_d = (BC == '0) ? 1'b0 : lfsr_bit;
                    done_d    = (BC == '0);
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            hold_q    <= '0;
            key_q     <= '0;
            ph_q      <= '0;
            contact_q <= 1'b0;
            done_q    <= 1'b0;
            row_q     <= '1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hold_q    <= hold_d;
            key_q     <= key_d;
            ph_q      <= ph_d;
            contact_q <= contact_d;
            done_q    <= done_d;
            row_q     <= row_fn;
        end
    end

    // closed contact pulls the selected row low only while its column is driven low
    assign row_fn      = (contact_q && !col_i[key_q[1:0]]) ? ~(KEY_ROWS'(1) << key_q[3:2]) : '1;
    assign row_o       = ROW_REG ? row_q : row_fn;
    assign contact_o   = contact_q;
    assign key_ready_o = (state_q == IDLE);
    assign busy_o      = (state_q != IDLE);
    assign done_o      = done_q;

endmodule

// File: tb/tb_keypad_matrix_emulator.sv
// tb_keypad_matrix_emulator: three emulator configurations driven in lockstep and
// scoreboarded against per-press contact traces built from the behavioural rules.
module tb_keypad_matrix_emulator;

    localparam int          BCF[3]  = '{0, 64, 8};
    localparam int          PRF[3]  = '{1, 4, 3};
    localparam int          RRF[3]  = '{0, 0, 1};
    localparam logic [15:0] SDF[3]  = '{16'hACE1, 16'hACE1, 16'h1D0F};

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        key_valid = 1'b0;
    logic [3:0]  key_code = '0;
    logic [15:0] hold_cycles = '0;
    logic [3:0]  col = 4'hF;
    logic [2:0]  key_ready, contact, busy, done;
    logic [3:0]  row [3];

    int checks = 0;
    int errors = 0;

    int          left [3]     = '{0, 0, 0};
    int          wp [3]       = '{0, 0, 0};
    int          rp [3]       = '{0, 0, 0};
    int          flush_to [3] = '{0, 0, 0};
    int          cur_len [3]  = '{0, 0, 0};
    int          bcnt [3]     = '{0, 0, 0};
    bit          done_exp [3] = '{0, 0, 0};
    logic [3:0]  key_m [3]    = '{4'h0, 4'h0, 4'h0};
    logic [3:0]  fprev [3]    = '{4'hF, 4'hF, 4'hF};
    logic [15:0] lf [3];
    bit          tr [3][1024];
    bit          started = 1'b0;

    always #5 clk = ~clk;

    keypad_matrix_emulator #(.BOUNCE_CYCLES(0), .BOUNCE_PERIOD(1), .LFSR_SEED(16'hACE1), .ROW_REG(1'b0)) dut0 (
        .clk_i(clk), .reset_i(reset), .key_valid_i(key_valid), .key_code_i(key_code),
        .hold_cycles_i(hold_cycles), .key_ready_o(key_ready[0]), .col_i(col), .row_o(row[0]),
        .contact_o(contact[0]), .busy_o(busy[0]), .done_o(done[0]));

    keypad_matrix_emulator #(.BOUNCE_CYCLES(64), .BOUNCE_PERIOD(4), .LFSR_SEED(16'hACE1), .ROW_REG(1'b0)) dut1 (
        .clk_i(clk), .reset_i(reset), .key_valid_i(key_valid), .key_code_i(key_code),
        .hold_cycles_i(hold_cycles), .key_ready_o(key_ready[1]), .col_i(col), .row_o(row[1]),
        .contact_o(contact[1]), .busy_o(busy[1]), .done_o(done[1]));

    keypad_matrix_emulator #(.BOUNCE_CYCLES(8), .BOUNCE_PERIOD(3), .LFSR_SEED(16'h1D0F), .ROW_REG(1'b1)) dut2 (
        .clk_i(clk), .reset_i(reset), .key_valid_i(key_valid), .key_code_i(key_code),
        .hold_cycles_i(hold_cycles), .key_ready_o(key_ready[2]), .col_i(col), .row_o(row[2]),
        .contact_o(contact[2]), .busy_o(busy[2]), .done_o(done[2]));

    function automatic logic [15:0] lstep(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    // contact during busy cycle j of a press whose transfer cycle saw LFSR value v0
    function automatic bit exp_bit(input logic [15:0] v0, input int b, input int p, input int h, input int j);
        int n;
        logic [15:0] v;
        if (j >= b && j < b + h) return 1'b1;
        n = (j < b) ? (j / p) * p : b + h + ((j - b - h) / p) * p;
        v = v0;
        repeat (n) v = lstep(v);
        return v[0];
    endfunction

    task automatic chk(input string nm, input int i, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s dut%0d t=%0t got=%0h expected=%0h", nm, i, $time, act, exp);
        end
    endtask

    // reference model: accepts requests when idle and pushes the expected trace
    always @(posedge clk) begin
        int h, l;
        started = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (reset) begin
                lf[i]       = SDF[i];
                left[i]     = 0;
                done_exp[i] = 1'b0;
                flush_to[i] = wp[i];
            end else begin
                done_exp[i] = (left[i] == 1);
                if (left[i] > 0) left[i]--;
                else if (key_valid) begin
                    h = (hold_cycles == 16'd0) ? 1 : int'(hold_cycles);
                    l = 2 * BCF[i] + h;
                    for (int j = 0; j < l; j++)
                        tr[i][(wp[i] + j) % 1024] = exp_bit(lf[i], BCF[i], PRF[i], h, j);
                    wp[i]      += l;
                    left[i]     = l;
                    cur_len[i]  = l;
                    key_m[i]    = key_code;
                end
                lf[i] = lstep(lf[i]);
            end
        end
    end

    // monitor: pops one expected contact per busy cycle the DUT presents
    always @(negedge clk) begin
        bit ce;
        logic [3:0] f;
        if (started) begin
            for (int i = 0; i < 3; i++) begin
                if (rp[i] < flush_to[i]) rp[i] = flush_to[i];
                chk("busy", i, int'(busy[i]), int'(left[i] > 0));
                chk("key_ready", i, int'(key_ready[i]), int'(left[i] == 0));
                chk("done", i, int'(done[i]), int'(done_exp[i]));
                ce = 1'b0;
                if (busy[i]) begin
                    if (rp[i] == wp[i]) begin
                        checks++;
                        errors++;
                        $display("FAIL trace_empty dut%0d t=%0t got=busy expected=idle", i, $time);
                    end else begin
                        ce = tr[i][rp[i] % 1024];
                        rp[i]++;
                    end
                    bcnt[i]++;
                end
                chk("contact", i, int'(contact[i]), int'(ce));
                for (int r = 0; r < 4; r++)
                    f[r] = !(ce && r == int'(key_m[i][3:2]) && col[key_m[i][1:0]] == 1'b0);
                chk("row", i, int'(row[i]), int'(RRF[i] != 0 ? fprev[i] : f));
                fprev[i] = reset ? 4'hF : f;
                if (done[i]) chk("busy_len", i, bcnt[i], cur_len[i]);
                if (!busy[i]) bcnt[i] = 0;
            end
        end
    end

    function automatic logic [3:0] col_pat(input int mode, input logic [3:0] fix, input int n);
        logic [3:0] one = 4'b0001;
        case (mode)
            0: return fix;
            1: return 4'($urandom);
            2: return ~(one << $urandom_range(0, 3));
            default: return ~(one << (n % 4));
        endcase
    endfunction

    task automatic press(input logic [3:0] code, input logic [15:0] hold, input int mode,
                         input logic [3:0] fix, input bit spam, input int rst_at);
        int n = 0;
        while (|busy && n < 2000) begin
            @(posedge clk);
            #1 n++;
        end
        if (n >= 2000) begin
            checks++;
            errors++;
            $display("FAIL wait_ready t=%0t got=busy expected=ready", $time);
        end
        @(posedge clk);
        #1;
        key_valid   = 1'b1;
        key_code    = code;
        hold_cycles = hold;
        col         = col_pat(mode, fix, 0);
        n = 0;
        do begin
            @(posedge clk);
            #1 n++;
            key_valid = spam && n < 6;
            key_code  = spam ? 4'h3 : code;
            col       = col_pat(mode, fix, n);
            reset     = (n == rst_at);
        end while (((|busy) || reset) && n < 2000);
        reset     = 1'b0;
        key_valid = 1'b0;
        if (n >= 2000) begin
            checks++;
            errors++;
            $display("FAIL wait_done t=%0t got=busy expected=idle", $time);
        end
    endtask

    initial begin
        key_valid   = 1'b1;
        key_code    = 4'h7;
        hold_cycles = 16'd5;
        repeat (3) @(posedge clk);
        #1;
        reset     = 1'b0;
        key_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        press(4'b0110, 16'd10, 0, 4'b1011, 1'b0, -1);
        press(4'b0110, 16'd10, 3, 4'hF, 1'b0, -1);
        press(4'hF, 16'd20, 2, 4'hF, 1'b0, -1);
        press(4'hA, 16'd30, 1, 4'hF, 1'b1, -1);
        press(4'h5, 16'd100, 2, 4'hF, 1'b0, 5);
        press(4'h5, 16'd12, 2, 4'hF, 1'b0, -1);
        press(4'hC, 16'd0, 1, 4'hF, 1'b0, -1);
        press(4'h9, 16'd6, 0, 4'h0, 1'b0, -1);
        press(4'h2, 16'd9, 1, 4'hF, 1'b0, -1);
        press(4'hE, 16'd4, 3, 4'hF, 1'b0, -1);
        for (int k = 0; k < 12; k++)
            press(4'($urandom), 16'($urandom_range(0, 40)), $urandom_range(1, 3), 4'hF, 1'($urandom), -1);
        repeat (4) @(posedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
